// File: rtl/stream_mux_2to1.sv
// Round-robin 2:1 valid/ready stream merge with one registered output stage and a source tag.
// Define STREAM_MUX_CNT_EN to add the per-input accepted-beat counters cnt0/cnt1.
module stream_mux_2to1 #(
  parameter int DATA_W = 8
`ifdef STREAM_MUX_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
`ifdef STREAM_MUX_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
`endif
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic              last_src_q, last_src_d;
  logic              load_en;
  logic              grant_sel;
  logic              acc0, acc1;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_src_d  = last_src_q;

    load_en   = !out_valid_q || out_ready;
    // A tie goes to whichever input did not win last time.
    grant_sel = (in0_valid && in1_valid) ? !last_src_q : in1_valid;
    in0_ready = !rst && load_en && in0_valid && !grant_sel;
    in1_ready = !rst && load_en && in1_valid &&  grant_sel;
    acc0      = in0_valid && in0_ready;
    acc1      = in1_valid && in1_ready;

    if (acc0) begin
      out_valid_d = 1'b1;
      out_data_d  = in0_data;
      out_src_d   = 1'b0;
      last_src_d  = 1'b0;
    end else if (acc1) begin
      out_valid_d = 1'b1;
      out_data_d  = in1_data;
      out_src_d   = 1'b1;
      last_src_d  = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      last_src_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_src_q  <= last_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef STREAM_MUX_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q + (acc0 ? CNT_W'(1) : CNT_W'(0));
    cnt1_d = cnt1_q + (acc1 ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_stream_mux_2to1.sv
// Self-checking bench for stream_mux_2to1: directed scenarios plus a cycle model and
// scoreboard queue that predicts readies and every output beat.
module tb_stream_mux_2to1;

  localparam int DATA_W = 8;
`ifdef STREAM_MUX_CNT_EN
  localparam int CNT_W  = 4;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in0_valid, in0_ready;
  logic [DATA_W-1:0] in0_data;
  logic              in1_valid, in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
`ifdef STREAM_MUX_CNT_EN
  logic [CNT_W-1:0]  cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: expected {src, data} beats, model output-valid and last winner.
  logic [DATA_W:0] sbq[$];
  logic            m_valid = 1'b0;
  logic            m_last  = 1'b1;

  always #5 clk = ~clk;

  stream_mux_2to1 #(
    .DATA_W(DATA_W)
`ifdef STREAM_MUX_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef STREAM_MUX_CNT_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`endif
  );

  // Called at the falling edge: compare against the model, then advance it to the
  // state the coming rising edge will produce.
  task automatic sb_step();
    logic            ld, g0, g1;
    logic [DATA_W:0] exp;
    if (rst) begin
      sbq.delete();
      m_valid = 1'b0;
      m_last  = 1'b1;
      checks++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sb_in_reset: ready0=%b ready1=%b out_valid=%b, required 0 0 0",
                 in0_ready, in1_ready, out_valid);
      end
    end else begin
      ld = !m_valid || out_ready;
      g0 = ld && in0_valid && (!in1_valid || m_last);
      g1 = ld && in1_valid && (!in0_valid || !m_last);
      checks++;
      if ({in0_ready, in1_ready} !== {g0, g1}) begin
        errors++;
        $display("FAIL sb_ready: got ready0/1=%b%b, required %b%b", in0_ready, in1_ready, g0, g1);
      end
      checks++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("FAIL sb_out_valid: got %b, required %b", out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_beat: got src=%b data=%h, required no beat (queue empty)", out_src, out_data);
        end else begin
          exp = sbq[0];
          if ({out_src, out_data} !== exp) begin
            errors++;
            $display("FAIL sb_beat: got src=%b data=%h, required src=%b data=%h",
                     out_src, out_data, exp[DATA_W], exp[DATA_W-1:0]);
          end
          if (out_ready) void'(sbq.pop_front());
        end
      end
      if (g0) begin
        sbq.push_back({1'b0, in0_data});
        m_last = 1'b0;
      end
      if (g1) begin
        sbq.push_back({1'b1, in1_data});
        m_last = 1'b1;
      end
      if (g0 || g1) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
    end
  endtask

  // One clock: model step on the falling edge, return 1 time unit after the rising edge.
  task automatic cycle();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h3C;
    in1_valid = 1'b0; in1_data = 8'h00;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in0_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: ready0=%b out_valid=%b out_data=%h, required 0 0 00",
               in0_ready, out_valid, out_data);
    end
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (in0_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1", in0_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || out_src !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_beat: valid=%b data=%h src=%b, required 1 3c 0",
               out_valid, out_data, out_src);
    end
    in0_valid = 1'b0;
    cycle();
  endtask

  task automatic test_in0_only();
    in0_valid = 1'b1; in0_data = 8'hA5;
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL in0_only: valid=%b data=%h src=%b, required 1 a5 0", out_valid, out_data, out_src);
    end
    in0_valid = 1'b0;
    cycle();
  endtask

  // in0 won last, so the first tie goes to in1 and the sources then alternate.
  task automatic test_alternate(output logic next_src);
    logic exp_src;
    exp_src = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h11;
    in1_valid = 1'b1; in1_data = 8'h22;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== (exp_src ? 8'h22 : 8'h11)) begin
        errors++;
        $display("FAIL alternate[%0d]: valid=%b src=%b data=%h, required 1 %b %h",
                 i, out_valid, out_src, out_data, exp_src, exp_src ? 8'h22 : 8'h11);
      end
      exp_src = ~exp_src;
    end
    next_src = exp_src;
  endtask

  task automatic test_stall(input logic next_src);
    logic              held_src;
    logic [DATA_W-1:0] held_data;
    held_src  = ~next_src;
    held_data = held_src ? 8'h22 : 8'h11;
    out_ready = 1'b0;
    #1;
    checks++;
    if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready: ready0=%b ready1=%b, required 0 0", in0_ready, in1_ready);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_src !== held_src || out_data !== held_data ||
          in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b src=%b data=%h rdy=%b%b, required 1 %b %h 00",
                 i, out_valid, out_src, out_data, in0_ready, in1_ready, held_src, held_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ((next_src ? in1_ready : in0_ready) !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: ready0=%b ready1=%b, required input %b ready",
               in0_ready, in1_ready, next_src);
    end
    cycle();
    checks++;
    if (out_src !== next_src || out_data !== (next_src ? 8'h22 : 8'h11)) begin
      errors++;
      $display("FAIL stall_release_beat: src=%b data=%h, required %b %h",
               out_src, out_data, next_src, next_src ? 8'h22 : 8'h11);
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0 ||
        in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: valid=%b data=%h src=%b rdy=%b%b, required 0 00 0 00",
               out_valid, out_data, out_src, in0_ready, in1_ready);
    end
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_tie_ready: ready0=%b ready1=%b, required 1 0", in0_ready, in1_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL midreset_first_beat: valid=%b src=%b data=%h, required 1 0 11",
               out_valid, out_src, out_data);
    end
    cycle();
    checks++;
    if (out_src !== 1'b1 || out_data !== 8'h22) begin
      errors++;
      $display("FAIL midreset_second_beat: src=%b data=%h, required 1 22", out_src, out_data);
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      in0_valid = 1'($urandom_range(0, 1));
      in1_valid = 1'($urandom_range(0, 1));
      in0_data  = DATA_W'($urandom);
      in1_data  = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    checks++;
    if (sbq.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: queue=%0d out_valid=%b, required 0 0", sbq.size(), out_valid);
    end
  endtask

`ifdef STREAM_MUX_CNT_EN
  task automatic test_counters();
    rst = 1'b1;
    #1;
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h5A;
    in1_valid = 1'b0;
    for (int i = 0; i < 17; i++) cycle();
    in0_valid = 1'b0;
    in1_valid = 1'b1; in1_data = 8'hC3;
    for (int i = 0; i < 3; i++) cycle();
    in1_valid = 1'b0;
    cycle();
    checks++;
    if (cnt0 !== 4'd1 || cnt1 !== 4'd3) begin
      errors++;
      $display("FAIL counters: cnt0=%0d cnt1=%0d, required 1 3", cnt0, cnt1);
    end
  endtask
`endif

  initial begin
    logic next_src;
    test_reset();
    test_in0_only();
    test_alternate(next_src);
    test_stall(next_src);
    test_reset_midstream();
    test_back_to_back();
`ifdef STREAM_MUX_CNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
